// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel APB timer: register map, TCR layout,
// reset constants and the byte-strobe merge helper.
package timer_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned PSC_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_TCR      = 12'h000;
  localparam logic [ADDR_W-1:0] ADDR_TDR0     = 12'h004;
  localparam logic [ADDR_W-1:0] ADDR_TDR1     = 12'h008;
  localparam logic [ADDR_W-1:0] ADDR_TIER     = 12'h00C;
  localparam logic [ADDR_W-1:0] ADDR_TISR     = 12'h010;
  localparam logic [ADDR_W-1:0] ADDR_THCSR    = 12'h014;
  localparam logic [ADDR_W-1:0] ADDR_CMP_BASE = 12'h020;

  localparam logic [DATA_W-1:0] TCR_RST = 32'h0000_0100;
  localparam logic [DATA_W-1:0] CMP_RST = 32'hFFFF_FFFF;

  // TCR bit layout: [0] timer_en, [1] div_en, [11:8] div_val
  typedef struct packed {
    logic [19:0]      rsvd_hi;
    logic [DIV_W-1:0] div_val;
    logic [5:0]       rsvd_lo;
    logic             div_en;
    logic             timer_en;
  } tcr_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TCR,
    SEL_TDR0,
    SEL_TDR1,
    SEL_TIER,
    SEL_TISR,
    SEL_THCSR,
    SEL_CMP
  } reg_sel_e;

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_cnt.sv
// Prescaler plus 64-bit free-running counter with half-word load and clear.
module timer_cnt
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              div_en_i,
  input  logic [DIV_W-1:0]  div_val_i,
  input  logic              halt_i,
  input  logic              clr_i,
  input  logic              ld_lo_i,
  input  logic              ld_hi_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [PSC_W-1:0] psc_q, psc_d, psc_top;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run, tick;

  assign psc_top = (PSC_W'(1) << div_val_i) - PSC_W'(1);
  assign run     = en_i & ~halt_i;
  assign tick    = run & (~div_en_i | (psc_q == psc_top));

  // Loads take priority over the increment in the same cycle
  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      psc_d = '0;
      cnt_d = '0;
    end else begin
      if (run) psc_d = (!div_en_i || tick) ? '0 : psc_q + PSC_W'(1);
      if (ld_lo_i)      cnt_d[31:0]  = ld_data_i;
      else if (ld_hi_i) cnt_d[63:32] = ld_data_i;
      else if (tick)    cnt_d        = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      cnt_q <= '0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/timer_mch_apb.sv
// APB-attached 64-bit timer with NUM_CH compare channels, debug halt and
// per-channel sticky interrupts.
module timer_mch_apb
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned WAIT_ST = 0,
  parameter int unsigned MAX_DIV = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              tim_psel,
  input  logic              tim_penable,
  input  logic              tim_pwrite,
  input  logic [ADDR_W-1:0] tim_paddr,
  input  logic [DATA_W-1:0] tim_pwdata,
  input  logic [STRB_W-1:0] tim_pstrb,
  output logic [DATA_W-1:0] tim_prdata,
  output logic              tim_pready,
  output logic              tim_pslverr,
  input  logic              dbg_mode,
  output logic              tim_int,
  output logic [NUM_CH-1:0] tim_int_ch
);

  localparam int unsigned WS_W = 2;

  logic [WS_W-1:0]   ws_q, ws_d;
  logic              access, xfer_done, addr_err, tcr_err, err, wr_ok;
  reg_sel_e          sel;
  logic [1:0]        ch_sel;
  logic              cmp_hi_sel;
  logic [DATA_W-1:0] cur_val, wr_val;
  tcr_t              tcr_q, tcr_new, tcr_wr;
  logic [NUM_CH-1:0] tier_q, tisr_q, tisr_clr, match;
  logic [DATA_W-1:0] cmp_lo [NUM_CH];
  logic [DATA_W-1:0] cmp_hi [NUM_CH];
  logic              halt_req_q, halt_ack;
  logic [CNT_W-1:0]  cnt;

  assign access    = tim_psel & tim_penable;
  assign xfer_done = access & sys_rst_n & (ws_q == WS_W'(WAIT_ST));

  always_comb begin
    ws_d = ws_q;
    if (!access || xfer_done) ws_d = '0;
    else                      ws_d = ws_q + WS_W'(1);
  end

  // Word-aligned decode; CMP window covers only implemented channels
  always_comb begin
    sel        = SEL_NONE;
    ch_sel     = tim_paddr[4:3];
    cmp_hi_sel = tim_paddr[2];
    case ({tim_paddr[11:2], 2'b00})
      ADDR_TCR:   sel = SEL_TCR;
      ADDR_TDR0:  sel = SEL_TDR0;
      ADDR_TDR1:  sel = SEL_TDR1;
      ADDR_TIER:  sel = SEL_TIER;
      ADDR_TISR:  sel = SEL_TISR;
      ADDR_THCSR: sel = SEL_THCSR;
      default: begin
        if ((tim_paddr[11:5] == ADDR_CMP_BASE[11:5]) && ({1'b0, ch_sel} < 3'(NUM_CH)))
          sel = SEL_CMP;
      end
    endcase
  end

  always_comb begin
    cur_val = '0;
    case (sel)
      SEL_TCR:   cur_val = tcr_q;
      SEL_TDR0:  cur_val = cnt[31:0];
      SEL_TDR1:  cur_val = cnt[63:32];
      SEL_TIER:  cur_val = 32'(tier_q);
      SEL_TISR:  cur_val = 32'(tisr_q);
      SEL_THCSR: cur_val = {30'b0, halt_ack, halt_req_q};
      SEL_CMP: begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
          if (ch_sel == 2'(n)) cur_val = cmp_hi_sel ? cmp_hi[n] : cmp_lo[n];
        end
      end
      default:   cur_val = '0;
    endcase
  end

  assign wr_val  = apply_strb(cur_val, tim_pwdata, tim_pstrb);
  assign tcr_new = tcr_t'(wr_val);

  always_comb begin
    tcr_wr         = tcr_new;
    tcr_wr.rsvd_hi = '0;
    tcr_wr.rsvd_lo = '0;
  end

  // Divider settings are frozen while the timer runs
  assign tcr_err  = tim_pwrite & (sel == SEL_TCR) &
                    ((tcr_new.div_val > DIV_W'(MAX_DIV)) |
                     (tcr_q.timer_en & ((tcr_new.div_val != tcr_q.div_val) |
                                        (tcr_new.div_en  != tcr_q.div_en))));
  assign addr_err = (sel == SEL_NONE) | (tim_paddr[1:0] != 2'b00);
  assign err      = addr_err | tcr_err;
  assign wr_ok    = xfer_done & tim_pwrite & ~err;

  assign tim_pready  = xfer_done;
  assign tim_pslverr = xfer_done & err;
  assign tim_prdata  = (xfer_done & ~tim_pwrite & ~err) ? cur_val : '0;

  assign halt_ack = halt_req_q & dbg_mode;
  assign tisr_clr = (wr_ok && sel == SEL_TISR) ?
                    (tim_pwdata[NUM_CH-1:0] & {NUM_CH{tim_pstrb[0]}}) : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ws_q       <= '0;
      tcr_q      <= tcr_t'(TCR_RST);
      tier_q     <= '0;
      tisr_q     <= '0;
      halt_req_q <= 1'b0;
    end else begin
      ws_q   <= ws_d;
      tisr_q <= (tisr_q & ~tisr_clr) | match;
      if (wr_ok && sel == SEL_TCR)   tcr_q      <= tcr_wr;
      if (wr_ok && sel == SEL_TIER)  tier_q     <= wr_val[NUM_CH-1:0];
      if (wr_ok && sel == SEL_THCSR) halt_req_q <= wr_val[0];
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DATA_W-1:0] lo_q, hi_q;
    logic              wr_sel;

    assign wr_sel = wr_ok & (sel == SEL_CMP) & (ch_sel == 2'(n));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        lo_q <= CMP_RST;
        hi_q <= CMP_RST;
      end else if (wr_sel) begin
        if (cmp_hi_sel) hi_q <= wr_val;
        else            lo_q <= wr_val;
      end
    end

    assign cmp_lo[n] = lo_q;
    assign cmp_hi[n] = hi_q;
    assign match[n]  = ({hi_q, lo_q} == cnt);
  end

  timer_cnt u_cnt (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .en_i      (tcr_q.timer_en),
    .div_en_i  (tcr_q.div_en),
    .div_val_i (tcr_q.div_val),
    .halt_i    (halt_ack),
    .clr_i     (wr_ok & (sel == SEL_TCR) & tcr_q.timer_en & ~tcr_new.timer_en),
    .ld_lo_i   (wr_ok & (sel == SEL_TDR0)),
    .ld_hi_i   (wr_ok & (sel == SEL_TDR1)),
    .ld_data_i (wr_val),
    .cnt_o     (cnt)
  );

  assign tim_int_ch = tisr_q & tier_q;
  assign tim_int    = |tim_int_ch;

endmodule

// File: tb/tb_timer_mch_apb.sv
// Scoreboard bench for timer_mch_apb: driver pushes expected APB responses,
// a negedge monitor pops and compares them on every pready.
module tb_timer_mch_apb;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned WAIT_ST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        dbg_mode = 1'b1;
  logic        tim_int;
  logic [NUM_CH-1:0] tim_int_ch;

  always #5 clk = ~clk;

  timer_mch_apb #(.NUM_CH(NUM_CH), .WAIT_ST(WAIT_ST), .MAX_DIV(8)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .tim_psel    (psel),
    .tim_penable (penable),
    .tim_pwrite  (pwrite),
    .tim_paddr   (paddr),
    .tim_pwdata  (pwdata),
    .tim_pstrb   (pstrb),
    .tim_prdata  (prdata),
    .tim_pready  (pready),
    .tim_pslverr (pslverr),
    .dbg_mode    (dbg_mode),
    .tim_int     (tim_int),
    .tim_int_ch  (tim_int_ch)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cnt  = 0;

  // Reference register contents for the CMP/TIER space
  logic [31:0] m_cmp [2*NUM_CH];
  logic [31:0] m_tier;
  logic [11:0] rnd_addr [14] = '{12'h020, 12'h024, 12'h028, 12'h02C, 12'h00C, 12'h020,
                                 12'h030, 12'h034, 12'h018, 12'h01C, 12'h0FC, 12'h0E2,
                                 12'h022, 12'h400};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks every response against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      if (pready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pready: got pready with no pending transfer, required none");
        end else begin
          mon_e = sb_q.pop_front();
          chk({mon_e.nm, "_slverr"}, 64'(pslverr), 64'(mon_e.err));
          chk({mon_e.nm, "_prdata"}, 64'(prdata), 64'(mon_e.rdata));
          chk({mon_e.nm, "_wait"}, 64'(acc_cnt), 64'(WAIT_ST));
        end
        acc_cnt = 0;
      end else begin
        chk("wait_cycle_prdata", 64'(prdata), 64'd0);
        chk("wait_cycle_slverr", 64'(pslverr), 64'd0);
        acc_cnt = acc_cnt + 1;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // Called aligned to posedge+1; returns aligned so calls chain back-to-back
  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input bit ee, input string nm);
    exp_t e;
    int   n;
    e.rdata = er;
    e.err   = ee;
    e.nm    = nm;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n >= 16) break;
    end
    if (!pready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no pready after %0d cycles, required within %0d", nm, n, WAIT_ST + 1);
      if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic op(input bit wr, input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string nm);
    logic [31:0] mask, cur, er;
    bit          ee, is_cmp, is_tier;
    int          idx;
    mask    = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    is_cmp  = (a[1:0] == 2'b00) && (a >= 12'h020) && (a < 12'(32 + 8 * NUM_CH));
    is_tier = (a == 12'h00C);
    idx     = is_cmp ? int'((a - 12'h020) >> 2) : 0;
    ee      = !(is_cmp || is_tier);
    er      = '0;
    if (!ee) begin
      cur = is_tier ? m_tier : m_cmp[idx];
      if (wr) begin
        cur = (cur & ~mask) | (d & mask);
        if (is_tier) m_tier = cur & 32'((1 << NUM_CH) - 1);
        else         m_cmp[idx] = cur;
      end else begin
        er = cur;
      end
    end
    apb(wr, a, d, s, er, ee, nm);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] er, input string nm);
    apb(1'b0, a, 32'h0, 4'h0, er, 1'b0, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input bit ee, input string nm);
    apb(1'b1, a, d, 4'hF, 32'h0, ee, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(2 * NUM_CH); i++) m_cmp[i] = 32'hFFFF_FFFF;
    m_tier = '0;

    // Transfer attempted while reset is held must be ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_tim_int", 64'(tim_int), 64'd0);
    chk("rst_tim_int_ch", 64'(tim_int_ch), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd(12'h000, 32'h0000_0100, "rst_tcr");
    rd(12'h004, 32'h0, "rst_tdr0");
    rd(12'h008, 32'h0, "rst_tdr1");
    rd(12'h00C, 32'h0, "rst_tier");
    rd(12'h010, 32'h0, "rst_tisr");
    rd(12'h014, 32'h0, "rst_thcsr");
    op(1'b0, 12'h02C, 32'h0, 4'h0, "rst_cmp1_hi");

    // Incomplete handshakes must not write or return data
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 12'h020;
    pwdata = 32'h6666_9999; pstrb = 4'hF;
    repeat (3) begin @(negedge clk); chk("nosel_wr_pready", 64'(pready), 64'd0); end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    repeat (3) begin @(negedge clk); chk("noen_wr_pready", 64'(pready), 64'd0); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    op(1'b0, 12'h020, 32'h0, 4'h0, "cmp0_lo_after_nohs");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h020;
    repeat (3) begin @(negedge clk); chk("noen_rd_prdata", 64'(prdata), 64'd0); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk); chk("nosel_rd_prdata", 64'(prdata), 64'd0);
    @(posedge clk); #1;
    penable = 1'b0;

    // Byte strobes
    op(1'b1, 12'h020, 32'h1234_5678, 4'hF, "cmp0_lo_wr");
    op(1'b0, 12'h020, 32'h0, 4'h0, "cmp0_lo_rd");
    op(1'b1, 12'h020, 32'hAAAA_AAAA, 4'h3, "cmp0_lo_strb_wr");
    op(1'b0, 12'h020, 32'h0, 4'h0, "cmp0_lo_strb_rd");

    // Back-to-back writes with wait states
    op(1'b1, 12'h020, 32'h1111_1111, 4'hF, "b2b_cmp0_wr");
    op(1'b1, 12'h028, 32'h2222_2222, 4'hF, "b2b_cmp1_wr");
    op(1'b0, 12'h020, 32'h0, 4'h0, "b2b_cmp0_rd");
    op(1'b0, 12'h028, 32'h0, 4'h0, "b2b_cmp1_rd");

    // Error responses
    op(1'b0, 12'h0FC, 32'h0, 4'h0, "rd_unmapped");
    op(1'b0, 12'h0E2, 32'h0, 4'h0, "rd_misaligned");
    op(1'b1, 12'h030, 32'h0, 4'hF, "wr_cmp2_absent");
    wr(12'h000, 32'h0000_0900, 1'b1, "tcr_div9_wr");
    rd(12'h000, 32'h0000_0100, "tcr_after_div9");

    // Randomized traffic over CMP/TIER and unmapped space
    for (int i = 0; i < 80; i++) begin
      op(1'($urandom_range(0, 1)), rnd_addr[$urandom_range(0, 13)], $urandom,
         4'($urandom_range(0, 15)), "rnd");
    end

    // Halt, load, wrap and resume
    wr(12'h014, 32'h1, 1'b0, "thcsr_halt_wr");
    rd(12'h014, 32'h3, "thcsr_halted");
    wr(12'h008, 32'hFFFF_FFFF, 1'b0, "tdr1_wr");
    wr(12'h004, 32'hFFFF_FFFF, 1'b0, "tdr0_wr");
    wr(12'h000, 32'h0000_0001, 1'b0, "tcr_enable");
    rd(12'h000, 32'h0000_0001, "tcr_enabled_rd");
    rd(12'h004, 32'hFFFF_FFFF, "tdr0_frozen");
    rd(12'h008, 32'hFFFF_FFFF, "tdr1_frozen");
    dbg_mode = 1'b0;
    @(posedge clk); #1;
    dbg_mode = 1'b1;
    rd(12'h004, 32'h0, "tdr0_wrapped");
    rd(12'h008, 32'h0, "tdr1_wrapped");
    dbg_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    dbg_mode = 1'b1;
    rd(12'h004, 32'd10, "tdr0_resumed");
    rd(12'h008, 32'h0, "tdr1_resumed");

    // Match while halted; set wins over coincident W1C
    op(1'b1, 12'h024, 32'h0, 4'hF, "cmp0_hi_zero");
    op(1'b1, 12'h020, 32'd10, 4'hF, "cmp0_lo_ten");
    op(1'b1, 12'h00C, 32'h1, 4'hF, "tier_ch0");
    wr(12'h010, 32'h3, 1'b0, "tisr_w1c_on_match");
    rd(12'h010, 32'h1, "tisr_set_wins");
    @(negedge clk);
    chk("halted_tim_int", 64'(tim_int), 64'd1);
    chk("halted_tim_int_ch", 64'(tim_int_ch), 64'd1);
    @(posedge clk); #1;
    op(1'b1, 12'h020, 32'd5, 4'hF, "cmp0_lo_five");
    wr(12'h010, 32'h3, 1'b0, "tisr_w1c");
    rd(12'h010, 32'h0, "tisr_cleared");
    @(negedge clk);
    chk("cleared_tim_int", 64'(tim_int), 64'd0);
    @(posedge clk); #1;

    // Disable clears the counter; release halt
    wr(12'h000, 32'h0, 1'b0, "tcr_disable");
    rd(12'h004, 32'h0, "tdr0_after_disable");
    dbg_mode = 1'b0;
    rd(12'h014, 32'h1, "thcsr_no_dbg");
    wr(12'h014, 32'h0, 1'b0, "thcsr_release");

    // Divided count reaches the compare value
    wr(12'h000, 32'h0000_0203, 1'b0, "tcr_div4_enable");
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    chk("div_tim_int", 64'(tim_int), 64'd1);
    chk("div_tim_int_ch", 64'(tim_int_ch), 64'd1);
    @(posedge clk); #1;
    rd(12'h010, 32'h1, "div_tisr");
    wr(12'h000, 32'h0000_0303, 1'b1, "tcr_divval_change_running");
    wr(12'h000, 32'h0000_0201, 1'b1, "tcr_diven_change_running");
    rd(12'h000, 32'h0000_0203, "tcr_unchanged");
    wr(12'h000, 32'h0000_0202, 1'b0, "tcr_disable2");
    rd(12'h004, 32'h0, "tdr0_cleared");
    rd(12'h008, 32'h0, "tdr1_cleared");
    rd(12'h010, 32'h1, "tisr_sticky");

    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_mch_apb.md
TIMER_MCH_APB -- requirements
Module: timer_mch_apb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of 64-bit compare channels (legal 1..4).
REQ-002 SHALL have parameter WAIT_ST, default 0, APB wait states inserted per access (legal 0..3).
REQ-003 SHALL have parameter MAX_DIV, default 8, largest legal TCR.div_val (counter divide by 2^div_val).
REQ-004 SHALL have port sys_clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have ports tim_psel, tim_penable, tim_pwrite  in  1 each  APB control.
REQ-007 SHALL have ports tim_paddr in 12, tim_pwdata in 32, tim_pstrb in 4  APB address/data/byte strobes.
REQ-008 SHALL have ports tim_prdata out 32, tim_pready out 1, tim_pslverr out 1  APB response.
REQ-009 SHALL have port dbg_mode  in  1  debug-mode indication from the CPU.
REQ-010 SHALL have ports tim_int out 1 (combined) and tim_int_ch out NUM_CH (per channel).

Function
REQ-011 SHALL decode: 0x00 TCR, 0x04 TDR0 (cnt[31:0]), 0x08 TDR1 (cnt[63:32]), 0x0C TIER, 0x10 TISR, 0x14 THCSR, 0x20+8n CMPn_LO, 0x24+8n CMPn_HI for n<NUM_CH.
REQ-012 SHALL complete a transfer only when psel&penable; pready=1 for exactly one cycle after WAIT_ST cycles of access phase (WAIT_ST=0: pready in first access cycle).
REQ-013 SHALL update registers only on the pready cycle of a write; pstrb[i] gates byte i; no effect when psel or penable is low.
REQ-014 SHALL drive prdata with register data only on the pready cycle of a read, else 0x0000_0000; unmapped/reserved bits read 0.
REQ-015 SHALL assert pslverr with pready for: unmapped address, paddr[1:0]!=0, div_val>MAX_DIV write, TCR.div_val/div_en change while timer_en=1; erroneous writes SHALL leave all registers unchanged.
REQ-016 TCR: bit0 timer_en, bit1 div_en, bits[11:8] div_val; others read 0.
REQ-017 Counter SHALL increment by 1 per tick when timer_en=1 and halt_ack=0; tick = every cycle if div_en=0, else every 2^div_val cycles via internal prescaler (div_val=0 -> every cycle).
REQ-018 Counter 64-bit SHALL wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-019 timer_en 1->0 SHALL clear counter and prescaler to 0 in the next cycle.
REQ-020 APB write to TDR0/TDR1 SHALL load that half; write wins over same-cycle increment.
REQ-021 TISR[n] SHALL set when {CMPn_HI,CMPn_LO}==counter (including while halted or disabled), sticky; write 1 clears; set wins over same-cycle clear; write 0 no effect.
REQ-022 TIER[n] enables channel n; tim_int_ch[n]=TISR[n]&TIER[n]; tim_int=OR of tim_int_ch; both registered-free combinational from flops.
REQ-023 THCSR: bit0 halt_req (RW), bit1 halt_ack (RO) = halt_req & dbg_mode; halt freezes counter and prescaler.
REQ-024 Bits of TIER/TISR at index >= NUM_CH SHALL be read-only 0.

Reset
REQ-025 On sys_rst_n=0, SHALL immediately set: TCR=0x0000_0100, counter=0, prescaler=0, CMPn_LO/HI=0xFFFF_FFFF, TIER=0, TISR=0, THCSR=0, wait counter=0.
REQ-026 Outputs during reset: prdata=0, pready=0, pslverr=0, tim_int=0, tim_int_ch=0; a transfer in progress at reset is abandoned.

Structure
REQ-027 Address offsets, TCR field positions and reset constants SHALL live in shared package timer_pkg.
REQ-028 Prescaler+64-bit counter SHALL be one sub-module timer_cnt; APB decode, registers and interrupt logic in top.

Verification
REQ-029 Write CMP0_LO=0x1234_5678 pstrb=0xF, read back -> 0x1234_5678, pslverr=0; pstrb=0x3 write 0xAAAA_AAAA -> 0x1234_AAAA.
REQ-030 psel=0 or penable=0 during write 0x6666_9999 to CMP0_LO after reset -> reads 0xFFFF_FFFF; same on read -> prdata=0.
REQ-031 WAIT_ST=2: back-to-back writes CMP0_LO=0x1111_1111, CMP1_LO=0x2222_2222 -> pready on 3rd access cycle each, readback matches.
REQ-032 Read 0x0FC or 0x0E2 -> pslverr=1, prdata=0; write TCR div_val=9 -> pslverr=1, TCR stays 0x0000_0100.
REQ-033 div_en=1 div_val=2, CMP0={0,5}, TIER=1, timer_en=1 -> TISR[0]=1 and tim_int=1 after 20 cycles; W1C coinciding with match -> TISR stays 1.
REQ-034 halt_req=1, dbg_mode=1 -> counter frozen, THCSR reads 0x3; dbg_mode=0 -> resumes; TDR1/TDR0=0xFFFF_FFFF -> next tick counter=0.
